// File: rtl/up_down_seq_pkg.sv
// Shared types and default sizes for the up/down triangle-sweep sequencer.
package up_down_seq_pkg;

  localparam int W_DEF    = 3;
  localparam int NP_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/up_down_seq_ctrl_core.sv
// W-bit up/down step register: load has priority over a +/-1 step when enabled.
module updown_step_core #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         dir,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= dir ? count + W'(1) : count - W'(1);
    end
  end

endmodule

// File: rtl/up_down_seq_ctrl.sv
// Triangle-sweep sequencer: lo -> hi -> lo for a latched number of passes.
// Optional pause input enabled by defining UP_DOWN_SEQ_PAUSE_EN.
module up_down_seq_ctrl
  import up_down_seq_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NP_W = NP_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
`ifdef UP_DOWN_SEQ_PAUSE_EN
  input  logic            pause,
`endif
  input  logic            start,
  input  logic            abort,
  input  logic [W-1:0]    lo_lim,
  input  logic [W-1:0]    hi_lim,
  input  logic [NP_W-1:0] passes,
  output logic [W-1:0]    count,
  output logic            mode,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_t          state, state_n;
  logic [W-1:0]    lo_q, hi_q;
  logic [NP_W-1:0] pass_rem, pass_n;
  logic            err_q, err_n;
  logic            ld, latch, step_en, step_up;
  logic            hold;
  logic [W:0]      cnt_inc, lo_inc;

`ifdef UP_DOWN_SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Compares run one bit wider so hi = 2^W-1 cannot overflow.
  assign cnt_inc = {1'b0, count} + (W+1)'(1);
  assign lo_inc  = {1'b0, lo_q} + (W+1)'(1);

  always_comb begin
    state_n = state;
    pass_n  = pass_rem;
    err_n   = 1'b0;
    ld      = 1'b0;
    latch   = 1'b0;
    step_en = 1'b0;
    step_up = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!abort && start) begin
          if (lo_lim >= hi_lim || passes == '0) begin
            err_n = 1'b1;
          end else begin
            ld      = 1'b1;
            latch   = 1'b1;
            pass_n  = passes;
            state_n = ST_UP;
          end
        end
      end
      ST_UP: begin
        if (abort) begin
          state_n = ST_IDLE;
          pass_n  = '0;
        end else if (!hold) begin
          step_en = 1'b1;
          step_up = 1'b1;
          if (cnt_inc == {1'b0, hi_q}) state_n = ST_DOWN;
        end
      end
      ST_DOWN: begin
        if (abort) begin
          state_n = ST_IDLE;
          pass_n  = '0;
        end else if (!hold) begin
          step_en = 1'b1;
          if ({1'b0, count} == lo_inc) begin
            if (pass_rem == NP_W'(1)) begin
              state_n = ST_DONE;
              pass_n  = '0;
            end else begin
              pass_n  = pass_rem - NP_W'(1);
              state_n = ST_UP;
            end
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        pass_n  = '0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pass_rem <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      pass_rem <= pass_n;
      err_q    <= err_n;
    end
  end

  // Limits are plain data: only meaningful once a start has latched them.
  always_ff @(posedge clk) begin
    if (latch) begin
      lo_q <= lo_lim;
      hi_q <= hi_lim;
    end
  end

  updown_step_core #(.W(W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (lo_lim),
    .en       (step_en),
    .dir      (step_up),
    .count    (count)
  );

  assign mode = (state == ST_UP);
  assign busy = (state == ST_UP) || (state == ST_DOWN);
  assign done = (state == ST_DONE);
  assign err  = err_q;

endmodule
